// File: rtl/dmac_pkg.sv
// Shared types and encodings for the dmac single-channel DMA controller.
// Optional auto-initialise behaviour is selected with DMAC_AUTOINIT_EN.
package dmac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // MODE register as stored; bits 6:5 are reserved and not kept.
  typedef struct packed {
    logic       en;
    logic       dec;
    logic [1:0] xfer;
    logic [1:0] dir;
  } mode_t;

  localparam logic [1:0] SEL_MODE   = 2'b00;
  localparam logic [1:0] SEL_COUNT  = 2'b01;
  localparam logic [1:0] SEL_ADDR   = 2'b11;

  localparam logic [1:0] DIR_IO2MEM = 2'b01;
  localparam logic [1:0] DIR_MEM2IO = 2'b10;

  localparam logic [1:0] XFER_STEAL = 2'b01;
  localparam logic [1:0] XFER_TRANS = 2'b10;

  function automatic logic dir_valid(input logic [1:0] dir);
    return (dir == DIR_IO2MEM) || (dir == DIR_MEM2IO);
  endfunction

endpackage

// File: rtl/dmac_regs.sv
// dmac register file: MODE, COUNT, ADDR and their per-byte update.
// With DMAC_AUTOINIT_EN, COUNT/ADDR writes are mirrored into reload shadows.
module dmac_regs
  import dmac_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [1:0]    sel,
  input  logic [AW-1:0] wdata,
  input  logic          step,
  input  logic          clr_en,
`ifdef DMAC_AUTOINIT_EN
  input  logic          reload,
`endif
  output mode_t         mode_r,
  output logic [AW-1:0] count_r,
  output logic [AW-1:0] addr_nxt_s
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  mode_t         mode_nxt_s;
  logic [AW-1:0] count_nxt_s;
  logic [AW-1:0] addr_r;
`ifdef DMAC_AUTOINIT_EN
  logic [AW-1:0] count_sh_r;
  logic [AW-1:0] addr_sh_r;
`endif

  // Next value of each register: CPU write first, then per-byte step or reload
  always_comb begin
    mode_nxt_s  = mode_r;
    count_nxt_s = count_r;
    addr_nxt_s  = addr_r;
    if (wr_en && (sel == SEL_MODE)) begin
      mode_nxt_s = '{en: wdata[7], dec: wdata[4], xfer: wdata[3:2], dir: wdata[1:0]};
    end else if (clr_en) begin
      mode_nxt_s.en = 1'b0;
    end else begin
      mode_nxt_s = mode_r;
    end
    if (wr_en && (sel == SEL_COUNT)) begin
      count_nxt_s = wdata;
    end else if (step) begin
      count_nxt_s = count_r - ONE;
`ifdef DMAC_AUTOINIT_EN
    end else if (reload) begin
      count_nxt_s = count_sh_r;
`endif
    end else begin
      count_nxt_s = count_r;
    end
    if (wr_en && (sel == SEL_ADDR)) begin
      addr_nxt_s = wdata;
    end else if (step) begin
      addr_nxt_s = mode_r.dec ? (addr_r - ONE) : (addr_r + ONE);
`ifdef DMAC_AUTOINIT_EN
    end else if (reload) begin
      addr_nxt_s = addr_sh_r;
`endif
    end else begin
      addr_nxt_s = addr_r;
    end
  end

  // Register state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_r  <= '{en: 1'b0, dec: 1'b0, xfer: 2'b00, dir: 2'b00};
      count_r <= {AW{1'b0}};
      addr_r  <= {AW{1'b0}};
    end else begin
      mode_r  <= mode_nxt_s;
      count_r <= count_nxt_s;
      addr_r  <= addr_nxt_s;
    end
  end

`ifdef DMAC_AUTOINIT_EN
  // Shadow copies restored on terminal count
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_sh_r <= {AW{1'b0}};
      addr_sh_r  <= {AW{1'b0}};
    end else begin
      if (wr_en && (sel == SEL_COUNT)) count_sh_r <= wdata;
      if (wr_en && (sel == SEL_ADDR))  addr_sh_r  <= wdata;
    end
  end
`endif

endmodule

// File: rtl/dmac.sv
// dmac top: transfer FSM, bus handshakes and strobe decode, all outputs registered.
// Define DMAC_AUTOINIT_EN to reload COUNT/ADDR and re-arm on terminal count.
module dmac
  import dmac_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          DREQ,
  input  logic          RDY,
  input  logic          HLDA,
  input  logic          BG,
  input  logic          REGW,
  input  logic [1:0]    REGSEL,
  input  logic [AW-1:0] Setup,
  input  logic [DW-1:0] Data_in,
  output logic          HLD,
  output logic          DACK,
  output logic          MEMR,
  output logic          MEMW,
  output logic          IOR,
  output logic          IOW,
  output logic          EOP,
  output logic [AW-1:0] Addrbus,
  output logic [DW-1:0] Data_out
);

  state_e        state_r, next_s;
  mode_t         mode_r;
  logic [AW-1:0] count_r, addr_nxt_s;
  logic [DW-1:0] buf_r, buf_nxt_s;
  logic          wr_en_s, step_s, clr_en_s, go_s, zero_s, last_s, bus_s;
  logic          hld_s, memr_s, memw_s, ior_s, iow_s, eop_s;
  logic [AW-1:0] addr_out_s;
  logic [DW-1:0] data_out_s;

  assign wr_en_s = REGW && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign step_s  = (state_r == ST_NEXT);
  // A pending CPU write holds off a new start so MODE never changes under a live transfer.
  assign go_s    = !REGW && mode_r.en && dir_valid(mode_r.dir);
  assign zero_s  = (count_r == {AW{1'b0}});
  assign last_s  = (count_r == {{(AW-1){1'b0}}, 1'b1});
`ifdef DMAC_AUTOINIT_EN
  assign clr_en_s = 1'b0;
`else
  assign clr_en_s = (state_r == ST_DONE);
`endif

  dmac_regs #(.AW(AW)) u_regs (
    .clk        (CLK),
    .rst_n      (RST),
    .wr_en      (wr_en_s),
    .sel        (REGSEL),
    .wdata      (Setup),
    .step       (step_s),
    .clr_en     (clr_en_s),
`ifdef DMAC_AUTOINIT_EN
    .reload     (state_r == ST_DONE),
`endif
    .mode_r     (mode_r),
    .count_r    (count_r),
    .addr_nxt_s (addr_nxt_s)
  );

  // Next-state selection
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!go_s)                          next_s = ST_IDLE;
        else if (zero_s)                    next_s = ST_DONE;
        else if (!DREQ)                     next_s = ST_IDLE;
        else if (mode_r.xfer == XFER_TRANS) next_s = BG ? ST_READ : ST_IDLE;
        else                                next_s = ST_REQ;
      end
      ST_REQ:   next_s = (HLDA && DREQ) ? ST_READ : ST_REQ;
      ST_READ:  next_s = RDY ? ST_WRITE : ST_READ;
      ST_WRITE: next_s = RDY ? ST_NEXT : ST_WRITE;
      ST_NEXT: begin
        if (last_s) begin
          next_s = ST_DONE;
        end else begin
          case (mode_r.xfer)
            XFER_TRANS, XFER_STEAL: next_s = ST_IDLE;
            default:                next_s = (DREQ && HLDA) ? ST_READ : ST_REQ;
          endcase
        end
      end
`ifdef DMAC_AUTOINIT_EN
      ST_DONE:  next_s = ST_IDLE;
`else
      ST_DONE:  next_s = REGW ? ST_IDLE : ST_DONE;
`endif
      default:  next_s = ST_IDLE;
    endcase
  end

  // Output values decoded from the state being entered
  always_comb begin
    memr_s = 1'b0;
    memw_s = 1'b0;
    ior_s  = 1'b0;
    iow_s  = 1'b0;
    case (next_s)
      ST_READ: begin
        ior_s  = (mode_r.dir == DIR_IO2MEM);
        memr_s = (mode_r.dir == DIR_MEM2IO);
      end
      ST_WRITE: begin
        memw_s = (mode_r.dir == DIR_IO2MEM);
        iow_s  = (mode_r.dir == DIR_MEM2IO);
      end
      default: begin
        memr_s = 1'b0;
        iow_s  = 1'b0;
      end
    endcase
    buf_nxt_s  = ((state_r == ST_READ) && RDY) ? Data_in : buf_r;
    bus_s      = (next_s == ST_READ) || (next_s == ST_WRITE);
    hld_s      = (next_s inside {ST_REQ, ST_READ, ST_WRITE, ST_NEXT}) &&
                 (mode_r.xfer != XFER_TRANS);
    eop_s      = (next_s == ST_DONE);
    addr_out_s = bus_s ? addr_nxt_s : {AW{1'b0}};
    data_out_s = (next_s == ST_WRITE) ? buf_nxt_s : {DW{1'b0}};
  end

  // State, data buffer and registered outputs
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r  <= ST_IDLE;
      buf_r    <= {DW{1'b0}};
      HLD      <= 1'b0;
      DACK     <= 1'b0;
      MEMR     <= 1'b0;
      MEMW     <= 1'b0;
      IOR      <= 1'b0;
      IOW      <= 1'b0;
      EOP      <= 1'b0;
      Addrbus  <= {AW{1'b0}};
      Data_out <= {DW{1'b0}};
    end else begin
      state_r  <= next_s;
      buf_r    <= buf_nxt_s;
      HLD      <= hld_s;
      DACK     <= bus_s;
      MEMR     <= memr_s;
      MEMW     <= memw_s;
      IOR      <= ior_s;
      IOW      <= iow_s;
      EOP      <= eop_s;
      Addrbus  <= addr_out_s;
      Data_out <= data_out_s;
    end
  end

endmodule

// File: tb/tb_dmac.sv
// Directed self-checking bench for dmac; outputs sampled and inputs driven on the falling edge.
module tb_dmac;

  logic        CLK, RST, DREQ, RDY, HLDA, BG, REGW;
  logic [1:0]  REGSEL;
  logic [15:0] Setup;
  logic [7:0]  Data_in;
  logic        HLD, DACK, MEMR, MEMW, IOR, IOW, EOP;
  logic [15:0] Addrbus;
  logic [7:0]  Data_out;

  int total = 0;
  int bad   = 0;

  dmac dut (
    .CLK(CLK), .RST(RST), .DREQ(DREQ), .RDY(RDY), .HLDA(HLDA), .BG(BG),
    .REGW(REGW), .REGSEL(REGSEL), .Setup(Setup), .Data_in(Data_in),
    .HLD(HLD), .DACK(DACK), .MEMR(MEMR), .MEMW(MEMW), .IOR(IOR), .IOW(IOW),
    .EOP(EOP), .Addrbus(Addrbus), .Data_out(Data_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_MEMR = 4'b1000;
  localparam logic [3:0] S_MEMW = 4'b0100;
  localparam logic [3:0] S_IOR  = 4'b0010;
  localparam logic [3:0] S_IOW  = 4'b0001;

  function automatic logic [3:0] strb();
    return {MEMR, MEMW, IOR, IOW};
  endfunction

  task automatic step();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic regwr(input logic [1:0] s, input logic [15:0] v);
    REGW = 1'b1; REGSEL = s; Setup = v;
    step();
    REGW = 1'b0;
  endtask

  // One byte from the cycle before READ through the NEXT cycle.
  task automatic xfer_byte(input logic [15:0] a, input logic [7:0] d,
                           input logic [3:0] rdv, input logic [3:0] wrv, input logic hld);
    Data_in = d;
    step();
    chk("rd_strb", strb(), rdv);
    chk("rd_addr", Addrbus, a);
    chk("rd_dack", DACK, 1'b1);
    chk("rd_hld", HLD, hld);
    step();
    chk("wr_strb", strb(), wrv);
    chk("wr_addr", Addrbus, a);
    chk("wr_data", Data_out, d);
    Data_in = ~d;
    step();
    chk("nx_strb", strb(), S_NONE);
    chk("nx_addr", Addrbus, 16'h0000);
    chk("nx_data", Data_out, 8'h00);
    chk("nx_dack", DACK, 1'b0);
    chk("nx_hld", HLD, hld);
  endtask

  initial begin
    RST = 1'b0; DREQ = 1'b0; RDY = 1'b1; HLDA = 1'b0; BG = 1'b0;
    REGW = 1'b0; REGSEL = 2'b00; Setup = 16'h0000; Data_in = 8'h00;
    step(); step();
    RST = 1'b1;
    chk("rst_strb", strb(), S_NONE);
    chk("rst_ctl", {HLD, DACK, EOP}, 3'b000);
    chk("rst_addr", Addrbus, 16'h0000);
    chk("rst_data", Data_out, 8'h00);

    // Transparent IO->Mem, three bytes from 0x0001
    regwr(2'b00, 16'h0089); regwr(2'b01, 16'd3); regwr(2'b11, 16'h0001);
    DREQ = 1'b1; BG = 1'b1; RDY = 1'b1;
    xfer_byte(16'h0001, 8'hA1, S_IOR, S_MEMW, 1'b0);
    step(); chk("t1_idle_strb", strb(), S_NONE); chk("t1_idle_eop", EOP, 1'b0);
    xfer_byte(16'h0002, 8'h3C, S_IOR, S_MEMW, 1'b0);
    step();
    xfer_byte(16'h0003, 8'h7E, S_IOR, S_MEMW, 1'b0);
    step(); chk("t1_eop", EOP, 1'b1); chk("t1_done_hld", HLD, 1'b0);
    step(); chk("t1_eop_held", EOP, 1'b1); chk("t1_done_strb", strb(), S_NONE);
    DREQ = 1'b0;
    regwr(2'b10, 16'h0000);
    chk("t1_eop_clr", EOP, 1'b0);

    // Transparent with BG withdrawn after the first byte
    regwr(2'b00, 16'h0089); regwr(2'b01, 16'd3); regwr(2'b11, 16'h0010);
    DREQ = 1'b1; BG = 1'b1;
    xfer_byte(16'h0010, 8'h11, S_IOR, S_MEMW, 1'b0);
    BG = 1'b0;
    step(); step();
    chk("t2_pause_strb", strb(), S_NONE); chk("t2_pause_dack", DACK, 1'b0);
    step();
    chk("t2_pause_strb2", strb(), S_NONE); chk("t2_pause_eop", EOP, 1'b0);
    BG = 1'b1;
    xfer_byte(16'h0011, 8'h22, S_IOR, S_MEMW, 1'b0);
    step();
    xfer_byte(16'h0012, 8'h33, S_IOR, S_MEMW, 1'b0);
    step(); chk("t2_eop", EOP, 1'b1);
    DREQ = 1'b0; regwr(2'b10, 16'h0000);

    // Burst Mem->IO, two bytes from 0x1000
    regwr(2'b00, 16'h0082); regwr(2'b01, 16'd2); regwr(2'b11, 16'h1000);
    HLDA = 1'b0; DREQ = 1'b1;
    step(); chk("t3_hld", HLD, 1'b1); chk("t3_req_strb", strb(), S_NONE);
    step(); chk("t3_hld_wait", HLD, 1'b1); chk("t3_req_dack", DACK, 1'b0);
    HLDA = 1'b1;
    xfer_byte(16'h1000, 8'hC3, S_MEMR, S_IOW, 1'b1);
    xfer_byte(16'h1001, 8'h96, S_MEMR, S_IOW, 1'b1);
    step(); chk("t3_eop", EOP, 1'b1); chk("t3_hld_drop", HLD, 1'b0);
    DREQ = 1'b0; regwr(2'b10, 16'h0000);

    // Cycle-steal Mem->IO, decrementing through the 16-bit wrap
    regwr(2'b00, 16'h0096); regwr(2'b01, 16'd2); regwr(2'b11, 16'h0000);
    DREQ = 1'b1;
    step(); chk("t4_hld", HLD, 1'b1);
    xfer_byte(16'h0000, 8'h42, S_MEMR, S_IOW, 1'b1);
    step(); chk("t4_steal_drop", HLD, 1'b0); chk("t4_idle_strb", strb(), S_NONE);
    step(); chk("t4_hld_again", HLD, 1'b1);
    xfer_byte(16'hFFFF, 8'h24, S_MEMR, S_IOW, 1'b1);
    step(); chk("t4_eop", EOP, 1'b1);
    DREQ = 1'b0; HLDA = 1'b0; regwr(2'b10, 16'h0000);

    // Three wait states in READ
    regwr(2'b00, 16'h0089); regwr(2'b01, 16'd1); regwr(2'b11, 16'h0200);
    RDY = 1'b0; BG = 1'b1; DREQ = 1'b1; Data_in = 8'h11;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t5_rdy_hold", strb(), S_IOR);
      chk("t5_rdy_addr", Addrbus, 16'h0200);
      if (i < 3) begin
        Data_in = 8'h20 + 8'(i);
        step();
      end
    end
    RDY = 1'b1; Data_in = 8'h5A;
    step(); chk("t5_wr_strb", strb(), S_MEMW); chk("t5_latch", Data_out, 8'h5A);
    step(); step(); chk("t5_eop", EOP, 1'b1);
    DREQ = 1'b0; regwr(2'b10, 16'h0000);

    // Terminal count already zero
    regwr(2'b00, 16'h0089); regwr(2'b01, 16'd0);
    step(); chk("t6_eop", EOP, 1'b1); chk("t6_strb", strb(), S_NONE); chk("t6_dack", DACK, 1'b0);
    step(); chk("t6_eop_held", EOP, 1'b1);
    regwr(2'b10, 16'hFFFF);
    chk("t6_eop_clr", EOP, 1'b0);
    step(); chk("t6_disabled", EOP, 1'b0);

    // Reset in the middle of a byte
    regwr(2'b00, 16'h0089); regwr(2'b01, 16'd5); regwr(2'b11, 16'h0300);
    DREQ = 1'b1; BG = 1'b1; RDY = 1'b1; Data_in = 8'h77;
    step(); chk("t7_read", strb(), S_IOR);
    RST = 1'b0;
    step(); chk("t7_abort_strb", strb(), S_NONE); chk("t7_abort_ctl", {DACK, EOP}, 2'b00);
    chk("t7_abort_addr", Addrbus, 16'h0000);
    RST = 1'b1; DREQ = 1'b0;
    step(); chk("t7_no_eop", EOP, 1'b0); chk("t7_idle_strb", strb(), S_NONE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmac.md
Name: dmac

Overview:
- Single-channel 8-bit DMA controller with a 16-bit address bus.
- CPU programs mode, count and address registers through a Setup/REGSEL/REGW write port.
- Moves bytes between an I/O device and memory in burst, cycle-stealing or transparent mode.
- Handshakes with the device (DREQ/DACK), with the CPU bus (HLD/HLDA or BG) and with memory/IO strobes and RDY wait states.

Parameters:
- AW, 16, address/count width.
- DW, 8, data width.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset, synchronous, active-low.
- DREQ  in  1  device request, level.
- RDY  in  1  ready; 0 inserts wait states.
- HLDA  in  1  hold acknowledge from CPU.
- BG  in  1  bus-grant/bus-idle indication, transparent mode only.
- REGW  in  1  register write strobe.
- REGSEL  in  2  register select.
- Setup  in  16  register write data.
- Data_in  in  8  read data from memory/IO.
- HLD  out  1  hold request to CPU.
- DACK  out  1  device acknowledge.
- MEMR, MEMW, IOR, IOW  out  1 each  active-high strobes.
- EOP  out  1  end of process.
- Addrbus  out  16  transfer address.
- Data_out  out  8  write data.

Behaviour:
- Reset (RST=0 at clock edge): all registers and outputs 0, state IDLE.
- Register write: REGW=1 in IDLE or DONE writes Setup into the selected register; writes in other states are ignored. A write in DONE also clears EOP and returns to IDLE.
- Register map:
  - 00 MODE[7:0] (Setup[7:0]).
  - 01 COUNT[15:0], in bytes.
  - 10 reserved, ignored.
  - 11 ADDR[15:0].
- MODE fields:
  - [1:0] direction: 01 IO->Mem (IOR then MEMW); 10 Mem->IO (MEMR then IOW); 00/11 no transfer.
  - [3:2] mode: 00 burst, 01 cycle-steal, 10 transparent, 11 treated as burst.
  - [4] 0 increment address, 1 decrement.
  - [7] channel enable.
- States: IDLE, REQ, READ, WRITE, NEXT, DONE.
- IDLE:
  - Enable=1 and valid direction and COUNT=0 -> DONE.
  - Enable=1 and valid direction and DREQ=1 and COUNT!=0: burst/cycle-steal -> REQ with HLD=1; transparent -> READ when BG=1, else wait.
- REQ: HLD=1; HLDA=1 -> READ.
- READ:
  - DACK=1; Addrbus=ADDR; IOR or MEMR asserted per direction.
  - Stays while RDY=0.
  - RDY=1: latch Data_in into buffer, -> WRITE.
- WRITE:
  - DACK=1; Addrbus=ADDR; Data_out=buffer; MEMW or IOW asserted.
  - Stays while RDY=0.
  - RDY=1 -> NEXT.
- NEXT: one cycle; COUNT-=1; ADDR+=1 or -=1 (16-bit wrap: 0xFFFF+1=0, 0-1=0xFFFF).
  - COUNT becomes 0 -> DONE.
  - Burst: DREQ=1 -> READ; DREQ=0 -> hold in IDLE-like wait with HLD kept.
  - Cycle-steal: drop HLD, -> IDLE.
  - Transparent: -> IDLE; the next byte starts only when BG=1.
- Mid-transfer loss of grant: BG falling or HLDA dropping mid-byte does not abort the current byte; it only gates the start of the next byte.
- DONE:
  - EOP=1 (level), HLD=0, strobes/DACK 0, MODE[7] cleared.
  - Held until a register write or reset.
- Outputs outside READ/WRITE: Addrbus=0, Data_out=0.
- Strobes are mutually exclusive; at most one of MEMR/MEMW/IOR/IOW is high.
- Reset mid-transfer aborts immediately with no EOP.

Optional Feature:
- Macro DMAC_AUTOINIT_EN.
- Defined: COUNT and ADDR writes are also copied to shadow registers. On terminal count, EOP pulses for exactly one cycle in DONE, COUNT/ADDR reload from the shadows, MODE[7] stays set, and the FSM returns to IDLE.
- Undefined: no shadows; behaviour as above.

Decomposition:
- dmac_pkg: state enum, REGSEL codes, MODE bit positions, direction/mode encodings.
- Sub-module dmac_regs: register file, COUNT/ADDR update logic and (optional) shadows.
- FSM and strobe decode live in dmac.

Test Plan:
- Transparent IO->Mem: MODE=0x89, COUNT=3, ADDR=0x0001, DREQ=RDY=BG=1 -> three IOR/MEMW pairs at Addrbus 1,2,3; Data_out echoes the latched Data_in; EOP=1 after the third byte; HLD stays 0.
- Transparent with BG dropped after byte 1 -> pause with no strobes; resumes when BG=1; three bytes total.
- Burst Mem->IO: MODE=0x82, COUNT=2, ADDR=0x1000 -> HLD=1; after HLDA, MEMR/IOW at 0x1000, 0x1001; EOP=1; HLD=0.
- Cycle-steal, decrement: MODE=0x96, COUNT=2, ADDR=0x0000 -> HLD drops between bytes; addresses 0x0000, 0xFFFF.
- RDY=0 for 3 cycles in READ -> IOR held 4 cycles, data latched only at RDY=1.
- COUNT=0 with enable -> EOP=1, no strobes. A REGW in DONE clears EOP.
